regfile_ctrl: RTL and testbench

Dual-client 16 x 32-bit ARM7 register file that serves the register read/write request ports driven by the execution sub-units (branch, data-processing, load/store). It services a registered read and a write per client per cycle. It resolves same-cycle write collisions and owns program-counter (r15) advance. It is the responder end of the `read_en/read_reg/read_value` and `write_en/write_reg/write_value` handshake.

---
 rtl/regfile_ctrl.sv | 79 +++++++
 tb/tb_regfile_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_ctrl.sv
// Dual-client 16 x 32-bit ARM7 register file with registered reads, per-client writes,
// A-over-B write collision resolution and r15 (program counter) auto-advance.
module regfile_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_read_en,
    input  logic [3:0]  a_read_reg,
    output logic [31:0] a_read_value,
    input  logic        a_write_en,
    input  logic [3:0]  a_write_reg,
    input  logic [31:0] a_write_value,
    input  logic        b_read_en,
    input  logic [3:0]  b_read_reg,
    output logic [31:0] b_read_value,
    input  logic        b_write_en,
    input  logic [3:0]  b_write_reg,
    input  logic [31:0] b_write_value,
    input  logic        pc_inc,
    output logic [31:0] pc_value
);

    logic [31:0] regs     [16];
    logic        wr_en    [16];
    logic [31:0] wr_data  [16];

    // Per-register update select: A write, then B write, then (r15 only) pc_inc.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            wr_en[i]   = 1'b0;
            wr_data[i] = 32'h0;
            if (a_write_en && a_write_reg == 4'(i)) begin
                wr_en[i]   = 1'b1;
                wr_data[i] = a_write_value;
            end else if (b_write_en && b_write_reg == 4'(i)) begin
                wr_en[i]   = 1'b1;
                wr_data[i] = b_write_value;
            end else if (i == 15 && pc_inc) begin
                wr_en[i]   = 1'b1;
                wr_data[i] = regs[15] + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= 32'h0;
            end
            regs[15] <= RESET_PC;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= wr_data[i];
                end
            end
        end
    end

    // Reads sample pre-edge contents; no write forwarding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_read_value <= 32'h0;
            b_read_value <= 32'h0;
        end else begin
            if (a_read_en) begin
                a_read_value <= regs[a_read_reg];
            end
            if (b_read_en) begin
                b_read_value <= regs[b_read_reg];
            end
        end
    end

    assign pc_value = regs[15];

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl: reset, read/write timing, collisions, r15 priority,
// branch-with-link sequence and asynchronous reset mid-write.
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_read_en, a_write_en, b_read_en, b_write_en, pc_inc;
    logic [3:0]  a_read_reg, a_write_reg, b_read_reg, b_write_reg;
    logic [31:0] a_read_value, b_read_value, a_write_value, b_write_value, pc_value;
    int total = 0;
    int bad = 0;

    regfile_ctrl #(.RESET_PC(32'h0000_0100), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst),
        .a_read_en(a_read_en), .a_read_reg(a_read_reg), .a_read_value(a_read_value),
        .a_write_en(a_write_en), .a_write_reg(a_write_reg), .a_write_value(a_write_value),
        .b_read_en(b_read_en), .b_read_reg(b_read_reg), .b_read_value(b_read_value),
        .b_write_en(b_write_en), .b_write_reg(b_write_reg), .b_write_value(b_write_value),
        .pc_inc(pc_inc), .pc_value(pc_value)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_read_en = 0; a_write_en = 0; b_read_en = 0; b_write_en = 0; pc_inc = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        a_read_reg = 0; a_write_reg = 0; b_read_reg = 0; b_write_reg = 0;
        a_write_value = 0; b_write_value = 0;
        tick(); tick();
        total++; if (a_read_value !== 32'h0) begin bad++; $display("FAIL rst_a got=%h exp=%h", a_read_value, 32'h0); end
        total++; if (b_read_value !== 32'h0) begin bad++; $display("FAIL rst_b got=%h exp=%h", b_read_value, 32'h0); end
        total++; if (pc_value !== 32'h100) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc_value, 32'h100); end
        rst = 0;
        a_read_en = 1; a_read_reg = 15; b_read_en = 1; b_read_reg = 3;
        tick(); idle();
        total++; if (a_read_value !== 32'h100) begin bad++; $display("FAIL rd_r15 got=%h exp=%h", a_read_value, 32'h100); end
        total++; if (b_read_value !== 32'h0) begin bad++; $display("FAIL rd_r3 got=%h exp=%h", b_read_value, 32'h0); end
    endtask

    task automatic test_write_read();
        a_write_en = 1; a_write_reg = 5; a_write_value = 32'hDEAD_BEEF;
        b_read_en = 1; b_read_reg = 5;
        tick(); a_write_en = 0;
        total++; if (b_read_value !== 32'h0) begin bad++; $display("FAIL rdw_old got=%h exp=%h", b_read_value, 32'h0); end
        tick(); idle();
        total++; if (b_read_value !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rdw_new got=%h exp=%h", b_read_value, 32'hDEAD_BEEF); end
        // Overwrite r5 while b_read_en is low: output must not follow.
        a_write_en = 1; a_write_reg = 5; a_write_value = 32'h0;
        for (int k = 0; k < 3; k++) begin
            tick(); a_write_en = 0;
            total++; if (b_read_value !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hold%0d got=%h exp=%h", k, b_read_value, 32'hDEAD_BEEF); end
        end
    endtask

    task automatic test_collision();
        a_write_en = 1; a_write_reg = 2; a_write_value = 32'h1111_1111;
        b_write_en = 1; b_write_reg = 2; b_write_value = 32'h2222_2222;
        tick(); idle();
        a_read_en = 1; a_read_reg = 2;
        tick(); idle();
        total++; if (a_read_value !== 32'h1111_1111) begin bad++; $display("FAIL coll got=%h exp=%h", a_read_value, 32'h1111_1111); end
        a_write_en = 1; a_write_reg = 7; a_write_value = 32'h7777_0007;
        b_write_en = 1; b_write_reg = 8; b_write_value = 32'h8888_0008;
        tick(); idle();
        a_read_en = 1; a_read_reg = 7; b_read_en = 1; b_read_reg = 8;
        tick(); idle();
        total++; if (a_read_value !== 32'h7777_0007) begin bad++; $display("FAIL dual_r7 got=%h exp=%h", a_read_value, 32'h7777_0007); end
        total++; if (b_read_value !== 32'h8888_0008) begin bad++; $display("FAIL dual_r8 got=%h exp=%h", b_read_value, 32'h8888_0008); end
    endtask

    task automatic test_pc();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h204; exp_pc[1] = 32'h208; exp_pc[2] = 32'h20C;
        a_write_en = 1; a_write_reg = 15; a_write_value = 32'h200;
        tick(); idle();
        total++; if (pc_value !== 32'h200) begin bad++; $display("FAIL pc_set got=%h exp=%h", pc_value, 32'h200); end
        pc_inc = 1; a_read_en = 1; a_read_reg = 15;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (pc_value !== exp_pc[k]) begin bad++; $display("FAIL pc_inc%0d got=%h exp=%h", k, pc_value, exp_pc[k]); end
        end
        // Read of r15 on the last increment edge returned the pre-edge value.
        total++; if (a_read_value !== 32'h208) begin bad++; $display("FAIL pc_rd_old got=%h exp=%h", a_read_value, 32'h208); end
        a_read_en = 0;
        b_write_en = 1; b_write_reg = 15; b_write_value = 32'h4000;
        tick(); idle();
        total++; if (pc_value !== 32'h4000) begin bad++; $display("FAIL pc_bwr got=%h exp=%h", pc_value, 32'h4000); end
        a_write_en = 1; a_write_reg = 15; a_write_value = 32'h5000;
        b_write_en = 1; b_write_reg = 15; b_write_value = 32'h6000; pc_inc = 1;
        tick(); idle();
        total++; if (pc_value !== 32'h5000) begin bad++; $display("FAIL pc_prio got=%h exp=%h", pc_value, 32'h5000); end
        a_write_en = 1; a_write_reg = 15; a_write_value = 32'hFFFF_FFFC;
        tick(); idle();
        pc_inc = 1;
        tick(); idle();
        total++; if (pc_value !== 32'h0) begin bad++; $display("FAIL pc_wrap got=%h exp=%h", pc_value, 32'h0); end
    endtask

    task automatic test_branch_link();
        logic [31:0] rd;
        a_write_en = 1; a_write_reg = 15; a_write_value = 32'h1000;
        tick(); idle();
        a_read_en = 1; a_read_reg = 15;
        tick(); idle();
        rd = a_read_value;
        total++; if (rd !== 32'h1000) begin bad++; $display("FAIL bl_rd got=%h exp=%h", rd, 32'h1000); end
        a_write_en = 1; a_write_reg = 14; a_write_value = rd + 32'd4;
        tick(); idle();
        a_read_en = 1; a_read_reg = 14;
        tick(); idle();
        total++; if (a_read_value !== 32'h1004) begin bad++; $display("FAIL bl_lr got=%h exp=%h", a_read_value, 32'h1004); end
        a_write_en = 1; a_write_reg = 15; a_write_value = rd + 32'd8 + (32'd2 << 2);
        tick(); idle();
        total++; if (pc_value !== 32'h1010) begin bad++; $display("FAIL bl_pc got=%h exp=%h", pc_value, 32'h1010); end
    endtask

    task automatic test_async_reset();
        a_write_en = 1; a_write_reg = 9; a_write_value = 32'h0001_2345;
        tick(); idle();
        a_read_en = 1; a_read_reg = 9; b_read_en = 1; b_read_reg = 9;
        tick(); idle();
        total++; if (b_read_value !== 32'h0001_2345) begin bad++; $display("FAIL pre_rst got=%h exp=%h", b_read_value, 32'h0001_2345); end
        a_write_en = 1; a_write_reg = 9; a_write_value = 32'h5555_5555;
        #2 rst = 1;
        #1;
        total++; if (a_read_value !== 32'h0) begin bad++; $display("FAIL async_a got=%h exp=%h", a_read_value, 32'h0); end
        total++; if (b_read_value !== 32'h0) begin bad++; $display("FAIL async_b got=%h exp=%h", b_read_value, 32'h0); end
        total++; if (pc_value !== 32'h100) begin bad++; $display("FAIL async_pc got=%h exp=%h", pc_value, 32'h100); end
        tick();
        rst = 0; idle();
        a_read_en = 1; a_read_reg = 9;
        tick(); idle();
        total++; if (a_read_value !== 32'h0) begin bad++; $display("FAIL post_rst_r9 got=%h exp=%h", a_read_value, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_pc();
        test_branch_link();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
